// File: rtl/cla_addsub_pipe.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready handshake and
// condition flags; each stage resolves WIDTH/STAGES bits of the carry chain.
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int NGRP  = SLICE / GROUP;

    // One slice: GROUP-bit block generate/propagate, then a flat
    // sum-of-products second level producing every block carry directly.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE-1:0] g, p, s;
        logic [NGRP-1:0]  bg, bp;
        logic [NGRP:0]    bc;
        logic             prod, c;
        g = a & b;
        p = a ^ b;
        s = '0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            bg[j] = 1'b0;
            bp[j] = 1'b1;
            for (int unsigned i = 0; i < GROUP; i++) begin
                bg[j] = g[j*GROUP+i] | (p[j*GROUP+i] & bg[j]);
                bp[j] = bp[j] & p[j*GROUP+i];
            end
        end
        bc[0] = cin;
        for (int unsigned j = 0; j < NGRP; j++) begin
            c = 1'b0;
            for (int unsigned m = 0; m <= j + 1; m++) begin
                if (m == 0) prod = cin;
                else        prod = bg[m-1];
                for (int unsigned q = m; q <= j; q++) prod = prod & bp[q];
                c = c | prod;
            end
            bc[j+1] = c;
        end
        for (int unsigned j = 0; j < NGRP; j++) begin
            c = bc[j];
            for (int unsigned i = 0; i < GROUP; i++) begin
                s[j*GROUP+i] = p[j*GROUP+i] ^ c;
                c = g[j*GROUP+i] | (p[j*GROUP+i] & c);
            end
        end
        return {bc[NGRP], s};
    endfunction

    // Rank 0 holds the captured operands; rank k holds slices 0..k-1 of Sum.
    logic [WIDTH-1:0] a_r   [STAGES];
    logic [WIDTH-1:0] bx_r  [STAGES];
    logic [WIDTH-1:0] sum_r [STAGES];
    logic             carry_r [STAGES];
    logic             vld     [STAGES];
    logic [SLICE:0]   res     [STAGES];
    logic [WIDTH-1:0] final_sum;
    logic             final_ovf;
    logic             stall;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            res[k] = cla_slice(a_r[k][k*SLICE +: SLICE], bx_r[k][k*SLICE +: SLICE], carry_r[k]);
        end
    end

    always_comb begin
        final_sum = sum_r[STAGES-1];
        final_sum[(STAGES-1)*SLICE +: SLICE] = res[STAGES-1][SLICE-1:0];
        final_ovf = (a_r[STAGES-1][WIDTH-1] == bx_r[STAGES-1][WIDTH-1]) &&
                    (final_sum[WIDTH-1] != a_r[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                vld[k]     <= 1'b0;
                a_r[k]     <= '0;
                bx_r[k]    <= '0;
                sum_r[k]   <= '0;
                carry_r[k] <= 1'b0;
            end
            out_valid <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
            Overflow  <= 1'b0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
        end else if (!stall) begin
            vld[0] <= in_valid;
            if (in_valid) begin
                a_r[0]     <= A;
                bx_r[0]    <= Sub ? ~B : B;
                carry_r[0] <= Sub | Cin;
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                vld[k]     <= vld[k-1];
                a_r[k]     <= a_r[k-1];
                bx_r[k]    <= bx_r[k-1];
                carry_r[k] <= res[k-1][SLICE];
                sum_r[k]   <= sum_r[k-1];
                sum_r[k][(k-1)*SLICE +: SLICE] <= res[k-1][SLICE-1:0];
            end
            out_valid <= vld[STAGES-1];
            // Bubbles leave the last result on the outputs untouched.
            if (vld[STAGES-1]) begin
                Sum      <= final_sum;
                Cout     <= res[STAGES-1][SLICE];
                Overflow <= final_ovf;
                Zero     <= (final_sum == '0);
                Negative <= final_sum[WIDTH-1];
            end
        end
    end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Self-checking bench for cla_addsub_pipe: directed flag vectors, streaming
// with backpressure, reset flush, and two extra parameter sets.
module tb_cla_addsub_pipe;
    localparam int MS = 2;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic        neg;
    } res_t;

    typedef struct {
        res_t r;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        m_in_valid, m_in_ready, m_sub, m_cin, m_out_valid, m_out_ready;
    logic [31:0] m_a, m_b, m_sum;
    logic        m_cout, m_ovf, m_zero, m_neg;

    logic        p8_in_valid, p8_in_ready, p8_sub, p8_cin, p8_out_valid, p8_out_ready;
    logic [7:0]  p8_a, p8_b, p8_sum;
    logic        p8_cout, p8_ovf, p8_zero, p8_neg;

    logic        p64_in_valid, p64_in_ready, p64_sub, p64_cin, p64_out_valid, p64_out_ready;
    logic [63:0] p64_a, p64_b, p64_sum;
    logic        p64_cout, p64_ovf, p64_zero, p64_neg;

    cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(MS)) dut (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .A(m_a), .B(m_b), .Sub(m_sub), .Cin(m_cin),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .Sum(m_sum),
        .Cout(m_cout), .Overflow(m_ovf), .Zero(m_zero), .Negative(m_neg)
    );

    cla_addsub_pipe #(.WIDTH(8), .GROUP(2), .STAGES(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(p8_in_valid), .in_ready(p8_in_ready),
        .A(p8_a), .B(p8_b), .Sub(p8_sub), .Cin(p8_cin),
        .out_valid(p8_out_valid), .out_ready(p8_out_ready), .Sum(p8_sum),
        .Cout(p8_cout), .Overflow(p8_ovf), .Zero(p8_zero), .Negative(p8_neg)
    );

    cla_addsub_pipe #(.WIDTH(64), .GROUP(4), .STAGES(1)) dut64 (
        .clk(clk), .rst(rst), .in_valid(p64_in_valid), .in_ready(p64_in_ready),
        .A(p64_a), .B(p64_b), .Sub(p64_sub), .Cin(p64_cin),
        .out_valid(p64_out_valid), .out_ready(p64_out_ready), .Sum(p64_sum),
        .Cout(p64_cout), .Overflow(p64_ovf), .Zero(p64_zero), .Negative(p64_neg)
    );

    // Reference: integer arithmetic on w-bit values; overflow as a signed range test.
    function automatic res_t model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                   input logic sub, input logic cin);
        res_t r;
        logic [63:0] mask, a, b;
        logic [64:0] full;
        logic signed [65:0] sa, sb, sr, hi, lo;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a = a_in & mask;
        b = b_in & mask;
        if (sub) begin
            full   = {1'b0, a} - {1'b0, b};
            r.cout = (a >= b);
        end else begin
            full   = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            r.cout = full[w];
        end
        r.sum = full[63:0] & mask;
        sa = $signed({2'b00, a});
        if (a[w-1]) sa = sa - (66'sd1 <<< w);
        sb = $signed({2'b00, b});
        if (b[w-1]) sb = sb - (66'sd1 <<< w);
        sr = sub ? (sa - sb) : (sa + sb + $signed({65'd0, cin}));
        hi = (66'sd1 <<< (w - 1)) - 66'sd1;
        lo = -(66'sd1 <<< (w - 1));
        r.ovf  = (sr > hi) || (sr < lo);
        r.zero = (r.sum == 64'd0);
        r.neg  = r.sum[w-1];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({m_out_valid, m_sum, m_cout, m_ovf, m_zero, m_neg} !== 37'd0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b sum=%h flags=%b%b%b%b want all zero",
                     m_out_valid, m_sum, m_cout, m_ovf, m_zero, m_neg);
        end
        checks++;
        if (m_in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b want 1", m_in_ready);
        end
        checks++;
        if ({p8_out_valid, p64_out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL reset_sweep_valid: got %b%b want 00", p8_out_valid, p64_out_valid);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [4] = '{32'h7FFFFFFF, 32'h80000000, 32'd10, 32'd3456};
        logic [31:0] vb [4] = '{32'd1, 32'hFFFFFFFF, 32'd10, -32'sd8347};
        logic [3:0]  vop[4] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000};
        logic [35:0] vex[4] = '{{32'h80000000, 4'b0101}, {32'h7FFFFFFF, 4'b1100},
                                {32'h00000000, 4'b1010}, {32'hFFFFECE5, 4'b0001}};
        m_out_ready = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            m_a = va[i];
            m_b = vb[i];
            m_sub = vop[i][3];
            m_cin = vop[i][2];
            m_in_valid = 1'b1;
            step();
            m_in_valid = 1'b0;
            for (int s = 1; s < MS; s++) begin
                step();
                checks++;
                if (m_out_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL directed_early_valid[%0d]: got %b want 0", i, m_out_valid);
                end
            end
            step();
            checks++;
            if ({m_out_valid, m_sum, m_cout, m_ovf, m_zero, m_neg} !== {1'b1, vex[i]}) begin
                fails++;
                $display("FAIL directed[%0d]: got valid=%b sum=%h c/v/z/n=%b%b%b%b want 1 %h %b",
                         i, m_out_valid, m_sum, m_cout, m_ovf, m_zero, m_neg,
                         vex[i][35:4], vex[i][3:0]);
            end
        end
        repeat (MS + 2) step();
    endtask

    task automatic test_back_to_back(input bit rand_ready);
        exp_t q[$];
        exp_t e;
        int sent = 0, got = 0, first_acc = -1, first_out = -1;
        for (int t = 0; t < 400 && got < 16; t++) begin
            if (m_out_valid) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    if (!rand_ready) begin
                        checks++;
                        if (first_out !== first_acc + MS) begin
                            fails++;
                            $display("FAIL b2b_latency: got %0d cycles want %0d", first_out - first_acc, MS);
                        end
                    end
                end
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL b2b_extra_beat[r%0d]: got sum=%h want no beat", rand_ready, m_sum);
                end else if ({m_sum, m_cout, m_ovf, m_zero, m_neg} !==
                             {q[0].r.sum[31:0], q[0].r.cout, q[0].r.ovf, q[0].r.zero, q[0].r.neg}) begin
                    fails++;
                    $display("FAIL b2b_data[r%0d] beat %0d: got %h %b%b%b%b want %h %b%b%b%b", rand_ready, got,
                             m_sum, m_cout, m_ovf, m_zero, m_neg, q[0].r.sum[31:0],
                             q[0].r.cout, q[0].r.ovf, q[0].r.zero, q[0].r.neg);
                end
            end
            if (!rand_ready && first_out >= 0) begin
                checks++;
                if (m_out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL b2b_gap: got out_valid=%b want 1 at beat %0d", m_out_valid, got);
                end
            end
            m_out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sent < 16) begin
                m_a = $urandom();
                m_b = $urandom();
                m_sub = 1'($urandom_range(0, 1));
                m_cin = 1'($urandom_range(0, 1));
                m_in_valid = 1'b1;
            end else begin
                m_in_valid = 1'b0;
            end
            #1;
            checks++;
            if (m_in_ready !== !(m_out_valid && !m_out_ready)) begin
                fails++;
                $display("FAIL b2b_in_ready: got %b want %b", m_in_ready, !(m_out_valid && !m_out_ready));
            end
            if (m_out_valid && m_out_ready && q.size() > 0) begin
                void'(q.pop_front());
                got++;
            end
            if (m_in_valid && m_in_ready) begin
                e.r = model(32, {32'd0, m_a}, {32'd0, m_b}, m_sub, m_cin);
                e.due = 0;
                q.push_back(e);
                if (first_acc < 0) first_acc = cyc + 1;
                sent++;
            end
            step();
        end
        m_in_valid = 1'b0;
        m_out_ready = 1'b1;
        checks++;
        if (got != 16 || q.size() != 0) begin
            fails++;
            $display("FAIL b2b_count[r%0d]: got %0d beats (%0d pending) want 16", rand_ready, got, q.size());
        end
        repeat (MS + 2) step();
    endtask

    task automatic test_reset_flush();
        m_out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_a = $urandom() | 32'h1;
            m_b = 32'd5;
            m_sub = 1'b0;
            m_cin = 1'b0;
            m_in_valid = 1'b1;
            step();
        end
        m_in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({m_out_valid, m_sum, m_cout, m_ovf, m_zero, m_neg, m_in_ready} !== {37'd0, 1'b1}) begin
            fails++;
            $display("FAIL flush_state: got valid=%b sum=%h flags=%b%b%b%b ready=%b want 0 0 0000 1",
                     m_out_valid, m_sum, m_cout, m_ovf, m_zero, m_neg, m_in_ready);
        end
        for (int i = 0; i < MS + 4; i++) begin
            step();
            checks++;
            if (m_out_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush_ghost_beat: got out_valid=%b sum=%h want 0", m_out_valid, m_sum);
            end
        end
    endtask

    task automatic test_sweep();
        exp_t q8[$], q64[$];
        exp_t e;
        p8_out_ready = 1'b1;
        p64_out_ready = 1'b1;
        for (int t = 0; t < 1010; t++) begin
            if (p8_out_valid) begin
                checks++;
                if (q8.size() == 0) begin
                    fails++;
                    $display("FAIL sweep8_extra: got sum=%h want no beat", p8_sum);
                end else begin
                    e = q8.pop_front();
                    if ({p8_sum, p8_cout, p8_ovf, p8_zero, p8_neg} !==
                        {e.r.sum[7:0], e.r.cout, e.r.ovf, e.r.zero, e.r.neg} || cyc != e.due) begin
                        fails++;
                        $display("FAIL sweep8: got %h %b%b%b%b at %0d want %h %b%b%b%b at %0d",
                                 p8_sum, p8_cout, p8_ovf, p8_zero, p8_neg, cyc,
                                 e.r.sum[7:0], e.r.cout, e.r.ovf, e.r.zero, e.r.neg, e.due);
                    end
                end
            end
            if (p64_out_valid) begin
                checks++;
                if (q64.size() == 0) begin
                    fails++;
                    $display("FAIL sweep64_extra: got sum=%h want no beat", p64_sum);
                end else begin
                    e = q64.pop_front();
                    if ({p64_sum, p64_cout, p64_ovf, p64_zero, p64_neg} !==
                        {e.r.sum, e.r.cout, e.r.ovf, e.r.zero, e.r.neg} || cyc != e.due) begin
                        fails++;
                        $display("FAIL sweep64: got %h %b%b%b%b at %0d want %h %b%b%b%b at %0d",
                                 p64_sum, p64_cout, p64_ovf, p64_zero, p64_neg, cyc,
                                 e.r.sum, e.r.cout, e.r.ovf, e.r.zero, e.r.neg, e.due);
                    end
                end
            end
            if (t < 1000) begin
                p8_a = 8'($urandom());
                p8_b = 8'($urandom());
                p8_sub = 1'($urandom_range(0, 1));
                p8_cin = 1'($urandom_range(0, 1));
                p8_in_valid = 1'b1;
                p64_a = {$urandom(), $urandom()};
                p64_b = {$urandom(), $urandom()};
                p64_sub = 1'($urandom_range(0, 1));
                p64_cin = 1'($urandom_range(0, 1));
                p64_in_valid = 1'b1;
                e.r = model(8, {56'd0, p8_a}, {56'd0, p8_b}, p8_sub, p8_cin);
                e.due = cyc + 1 + 4;
                q8.push_back(e);
                e.r = model(64, p64_a, p64_b, p64_sub, p64_cin);
                e.due = cyc + 1 + 1;
                q64.push_back(e);
            end else begin
                p8_in_valid = 1'b0;
                p64_in_valid = 1'b0;
            end
            step();
        end
        checks++;
        if (q8.size() != 0 || q64.size() != 0) begin
            fails++;
            $display("FAIL sweep_missing: got %0d/%0d beats pending want 0/0", q8.size(), q64.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        {m_in_valid, m_sub, m_cin, m_a, m_b} = '0;
        {p8_in_valid, p8_sub, p8_cin, p8_a, p8_b} = '0;
        {p64_in_valid, p64_sub, p64_cin, p64_a, p64_b} = '0;
        m_out_ready = 1'b1;
        p8_out_ready = 1'b1;
        p64_out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_flush();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
